dbus_req_arbiter: RTL

- Two-requester arbiter that shares one debug-module bus (dbus) target between two debug transports, e.g. the JTAG DTM (port 0) and a second transport (port 1).
- Exactly one transaction is in flight at a time. Request and response formats match the dbus encoding: req {addr, data, op}, resp {data, op}, with op/resp in the low bits.
- Grants round-robin, routes each response back to its owner, and synthesises an error response when the target times out.

---
 rtl/dbus_req_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dbus_req_arbiter.sv
// Two-port round-robin arbiter sharing one dbus target between two debug transports.
// One transaction in flight; a target timeout yields a synthetic error response.
module dbus_req_arbiter #(
  parameter int DEBUG_DATA_BITS = 34,
  parameter int DEBUG_ADDR_BITS = 5,
  parameter int DEBUG_OP_BITS   = 2,
  parameter int TIMEOUT         = 1024,
  localparam int REQ_W  = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS,
  localparam int RESP_W = DEBUG_OP_BITS + DEBUG_DATA_BITS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in0_req_valid,
  output logic              in0_req_ready,
  input  logic [REQ_W-1:0]  in0_req_bits,
  output logic              in0_resp_valid,
  input  logic              in0_resp_ready,
  output logic [RESP_W-1:0] in0_resp_bits,
  input  logic              in1_req_valid,
  output logic              in1_req_ready,
  input  logic [REQ_W-1:0]  in1_req_bits,
  output logic              in1_resp_valid,
  input  logic              in1_resp_ready,
  output logic [RESP_W-1:0] in1_resp_bits,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic [REQ_W-1:0]  dm_req_bits,
  input  logic              dm_resp_valid,
  output logic              dm_resp_ready,
  input  logic [RESP_W-1:0] dm_resp_bits,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_stale;
  logic [15:0]       r_cnt;
  logic [REQ_W-1:0]  r_req;
  logic [RESP_W-1:0] r_resp;
  logic              r_timeout_err;

  logic w_can_grant;
  logic w_gnt0;
  logic w_gnt1;
  logic w_drop;

  // Both valid: the port that did not win last time goes next.
  assign w_can_grant = (r_state == S_IDLE) && !r_stale;
  assign w_gnt0 = w_can_grant && in0_req_valid && (!in1_req_valid || r_last_grant);
  assign w_gnt1 = w_can_grant && in1_req_valid && (!in0_req_valid || !r_last_grant);

  // A late answer after a timeout is swallowed here so it never reaches a requester.
  assign w_drop = r_stale && (r_state != S_WAIT) && dm_resp_valid;

  assign in0_req_ready  = w_gnt0;
  assign in1_req_ready  = w_gnt1;
  assign dm_req_valid   = (r_state == S_REQ);
  assign dm_req_bits    = r_req;
  assign dm_resp_ready  = (r_state == S_WAIT) || (r_stale && (r_state != S_WAIT));
  assign in0_resp_valid = (r_state == S_RESP) && !r_owner;
  assign in1_resp_valid = (r_state == S_RESP) && r_owner;
  assign in0_resp_bits  = r_resp;
  assign in1_resp_bits  = r_resp;
  assign timeout_err    = r_timeout_err;
  assign dbg_state      = r_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_stale       <= 1'b0;
      r_cnt         <= 16'd0;
      r_req         <= '0;
      r_resp        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      if (w_drop) r_stale <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_req        <= w_gnt1 ? in1_req_bits : in0_req_bits;
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (dm_req_ready) begin
            r_cnt   <= 16'd0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the expiry cycle takes priority over the timeout.
          if (dm_resp_valid) begin
            r_resp  <= dm_resp_bits;
            r_state <= S_RESP;
          end else if (TO_EN && (r_cnt == TO_LAST)) begin
            r_resp        <= {{DEBUG_DATA_BITS{1'b0}}, DEBUG_OP_BITS'(2'b10)};
            r_stale       <= 1'b1;
            r_timeout_err <= 1'b1;
            r_state       <= S_RESP;
          end else if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if ((!r_owner && in0_resp_ready) || (r_owner && in1_resp_ready)) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
